psum_writer: RTL and testbench
==============================

# psum_writer

Receiver end of the PE sum-stage output handshake (PS). It accepts one PEROW-wide vector of saturated partial sums plus its pipeline control word, then drains it word by word into the partial-sum buffer write port (BW handshake). In D16 mode it packs two 16-bit sums per 32-bit word. It sits between the sum stage and the psum SRAM, and is the only writer of that SRAM for one PE column.

## Interface
Parameters:
- ADDRWD, 10: psum buffer word-address width.
- PEROW, PSUMDWD: not parameters; taken from PECfg (PSUMDWD = 32, PEROW even).

Ports (clock and reset first):
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  reset; asynchronous, active-low.
- PS_rdy  in  1  upstream has a valid vector.
- PS_ack  out  1  this block accepts. A transfer occurs when PS_rdy && PS_ack.
- i_sum  in  PSUMDWD × [PEROW]  partial sums. In D16 mode only bits [15:0] are meaningful.
- i_ppctl  in  PPctl  control word; fields used: psum_mode (D16/D32), addr [ADDRWD-1:0].
- BW_rdy  out  1  buffer write request valid.
- BW_ack  in  1  buffer accepts. A word is written when BW_rdy && BW_ack.
- o_bw_addr  out  ADDRWD  word address.
- o_bw_data  out  32  word data.
- o_done  out  1  one-cycle pulse when the last word of a vector is written.

## Operation
- FSM states: IDLE, WRITE. Reset state is IDLE.
- IDLE:
  - PS_ack = 1.
  - On a PS transfer: latch i_sum into a PEROW × PSUMDWD holding register; latch psum_mode, base = i_ppctl.addr; set cnt = 0; go to WRITE.
- WRITE:
  - BW_rdy = 1.
  - o_bw_addr = (base + cnt) mod 2^ADDRWD.
  - D32: o_bw_data = sum[cnt].
  - D16: o_bw_data = {sum[2·cnt+1][15:0], sum[2·cnt][15:0]}. The lower index goes in the low half.
  - Word count: NW = PEROW (D32) or PEROW/2 (D16).
  - On BW_ack: if cnt == NW-1, pulse o_done and finish the vector; otherwise cnt++.
- Vector finish:
  - PS_ack = 1 in the same cycle as the last BW ack. PS_ack is combinational from BW_ack.
  - If PS_rdy is also 1 in that cycle, latch the new vector, reset cnt to 0, and stay in WRITE (back-to-back).
  - Otherwise go to IDLE.
- PS_ack = 0 in WRITE except on the last-word ack cycle.
- While BW_rdy is held and BW_ack = 0: o_bw_addr and o_bw_data stay stable. Latched data must not change.
- The address wraps modulo 2^ADDRWD within a vector; there is no error flag.
- D16 sums are truncated to [15:0]; no re-saturation is applied.

## Timing
- Reset values: state IDLE, cnt 0, holding regs 0, BW_rdy 0, o_bw_addr 0, o_bw_data 0, o_done 0, PS_ack 1.
- Latency: PS transfer at cycle t → first BW_rdy at t+1.
- Vector duration with BW_ack held high: D32 takes PEROW cycles, D16 takes PEROW/2 cycles.
- Sustained throughput: one word per cycle, with no bubble between vectors.
- BW_rdy, o_bw_addr, o_bw_data are decoded from registered state/cnt. They have no combinational dependence on PS inputs.
- Reset asserted mid-vector: returns to IDLE immediately. The partial vector is discarded and the remaining words are not written.

## Structure
- PECfg already supplies PEROW and PSUMDWD.
- PECtlCfg supplies PPctl and the psum_mode enum (D16/D32).
- Add PSW_IDLE/PSW_WRITE as a state enum in PECtlCfg, and a BUFDWD = 32 constant.
- Single module, no sub-module. A word-select mux (mode-dependent) is kept inline.

## Test plan
Bench build uses PEROW = 4.
1. D32 single vector: sums {1, 2, 3, 4}, addr 8, BW_ack tied high → writes (8,1), (9,2), (10,3), (11,4) on consecutive cycles; o_done pulses on the 4th write; PS_ack is 0 for the first three WRITE cycles.
2. D16 packing: sums {0x1111, 0x2222, 0x3333, 0x4444}, addr 0 → (0, 0x22221111), (1, 0x44443333); o_done after 2 writes.
3. Back-pressure: BW_ack low for 3 cycles on word 1 → address and data stay stable, PS_ack stays 0, and no word is skipped or duplicated.
4. Back-to-back: PS_rdy held high with two D32 vectors → the second vector is accepted on the cycle the first vector's last word is written; 8 writes in 8 cycles with no gap.
5. Wrap: addr 1022 with ADDRWD = 10, D32 → addresses 1022, 1023, 0, 1.
6. Reset mid-vector after 2 writes → BW_rdy = 0 and PS_ack = 1 immediately; no further writes; the next vector starts cleanly at its own base address.

Source files
------------

// File: rtl/psum_writer_pkg.sv
// Shared configuration and types for the PE column partial-sum writer.
// Holds array geometry, the pipeline control word and the writer state encoding.
package psum_writer_pkg;

    localparam int unsigned PEROW      = 4;
    localparam int unsigned PSUMDWD    = 32;
    localparam int unsigned BUFDWD     = 32;
    localparam int unsigned CTL_ADDRWD = 10;

    typedef enum logic {
        PSUM_D32 = 1'b0,
        PSUM_D16 = 1'b1
    } psum_mode_e;

    typedef struct packed {
        psum_mode_e              psum_mode;
        logic [CTL_ADDRWD-1:0]   addr;
    } pp_ctl_t;

    typedef enum logic {
        PSW_IDLE  = 1'b0,
        PSW_WRITE = 1'b1
    } psw_state_e;

    function automatic int unsigned words_per_vec(input psum_mode_e mode);
        return (mode == PSUM_D16) ? PEROW / 2 : PEROW;
    endfunction

endpackage

// File: rtl/psum_writer.sv
// Accepts one vector of partial sums from the sum stage and drains it word by word
// into the psum buffer write port, packing two 16-bit sums per word in D16 mode.
module psum_writer
    import psum_writer_pkg::*;
#(
    parameter int unsigned ADDRWD = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            PS_rdy,
    output logic                            PS_ack,
    input  logic [PEROW-1:0][PSUMDWD-1:0]   i_sum,
    input  pp_ctl_t                         i_ppctl,
    output logic                            BW_rdy,
    input  logic                            BW_ack,
    output logic [ADDRWD-1:0]               o_bw_addr,
    output logic [BUFDWD-1:0]               o_bw_data,
    output logic                            o_done
);

    localparam int unsigned CntW  = (PEROW > 1) ? $clog2(PEROW) : 1;
    localparam int unsigned HalfW = BUFDWD / 2;

    psw_state_e                     state_q, state_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [PEROW-1:0][PSUMDWD-1:0]  sum_q, sum_d;
    psum_mode_e                     mode_q, mode_d;
    logic [ADDRWD-1:0]              base_q, base_d;

    logic                           ps_xfer;
    logic                           bw_xfer;
    logic                           last_word;
    logic [CntW-1:0]                last_cnt;
    logic [BUFDWD-1:0]              word;

    assign last_cnt  = CntW'(words_per_vec(mode_q) - 1);
    assign last_word = (cnt_q == last_cnt);
    assign bw_xfer   = (state_q == PSW_WRITE) && BW_ack;
    // Accept a new vector while idle, or in the very cycle the last word retires.
    assign PS_ack    = (state_q == PSW_IDLE) || (bw_xfer && last_word);
    assign ps_xfer   = PS_rdy && PS_ack;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= PSW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PSW_IDLE: begin
                if (ps_xfer) state_d = PSW_WRITE;
            end
            PSW_WRITE: begin
                if (bw_xfer && last_word) state_d = ps_xfer ? PSW_WRITE : PSW_IDLE;
            end
            default: state_d = PSW_IDLE;
        endcase
    end

    always_comb begin
        BW_rdy    = (state_q == PSW_WRITE);
        o_bw_addr = BW_rdy ? (base_q + ADDRWD'(cnt_q)) : '0;
        o_bw_data = BW_rdy ? word : '0;
        o_done    = bw_xfer && last_word;
    end

    always_comb begin
        sum_d  = sum_q;
        mode_d = mode_q;
        base_d = base_q;
        cnt_d  = cnt_q;
        if (ps_xfer) begin
            sum_d  = i_sum;
            mode_d = i_ppctl.psum_mode;
            base_d = i_ppctl.addr[ADDRWD-1:0];
            cnt_d  = '0;
        end else if (bw_xfer) begin
            cnt_d = last_word ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sum_q  <= '0;
            mode_q <= PSUM_D32;
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            mode_q <= mode_d;
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    // Word select: D32 takes one sum, D16 packs the lower-index sum into the low half.
    always_comb begin
        word = '0;
        if (mode_q == PSUM_D32) begin
            for (int unsigned w = 0; w < PEROW; w++) begin
                if (cnt_q == CntW'(w)) word = BUFDWD'(sum_q[w]);
            end
        end else begin
            for (int unsigned w = 0; w < PEROW / 2; w++) begin
                if (cnt_q == CntW'(w)) begin
                    word = {sum_q[2*w+1][HalfW-1:0], sum_q[2*w][HalfW-1:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_writer.sv
// Bench for psum_writer: directed and randomized vectors checked against a
// queue-based word-list model built from the sums, mode and base address.
module tb_psum_writer;
    import psum_writer_pkg::*;

    localparam int unsigned AW = 10;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           ps_rdy;
    logic                           ps_ack;
    logic [PEROW-1:0][PSUMDWD-1:0]  sum;
    pp_ctl_t                        ctl;
    logic                           bw_rdy;
    logic                           bw_ack;
    logic [AW-1:0]                  bw_addr;
    logic [BUFDWD-1:0]              bw_data;
    logic                           done;

    always #5 clk = ~clk;

    psum_writer #(.ADDRWD(AW)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .PS_rdy    (ps_rdy),
        .PS_ack    (ps_ack),
        .i_sum     (sum),
        .i_ppctl   (ctl),
        .BW_rdy    (bw_rdy),
        .BW_ack    (bw_ack),
        .o_bw_addr (bw_addr),
        .o_bw_data (bw_data),
        .o_done    (done)
    );

    typedef struct packed {
        logic [PEROW-1:0][31:0] s;
        psum_mode_e             mode;
        logic [AW-1:0]          base;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          last;
        logic [7:0]    idx;
    } exp_t;

    vec_t vec_q[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_vec(input logic [PEROW*32-1:0] s, input psum_mode_e m, input int b);
        vec_t v;
        v.s    = s;
        v.mode = m;
        v.base = AW'(b);
        vec_q.push_back(v);
    endtask

    // Expected write list for one vector, straight from the address/packing rules.
    function automatic void model_words(input vec_t v);
        int    nw;
        exp_t  e;
        longint d;
        nw = (v.mode == PSUM_D16) ? PEROW / 2 : PEROW;
        for (int k = 0; k < nw; k++) begin
            e.addr = AW'((int'(v.base) + k) % (1 << AW));
            if (v.mode == PSUM_D32) begin
                d = longint'(v.s[k]);
            end else begin
                d = longint'(v.s[2*k+1] % 32'd65536) * 65536 + longint'(v.s[2*k] % 32'd65536);
            end
            e.data = d[31:0];
            e.last = (k == nw - 1);
            e.idx  = 8'(k);
            exp_q.push_back(e);
        end
    endfunction

    // ack_mode: 0 = always ack, 1 = random ack, 2 = stall 3 cycles on word 1.
    task automatic run(input int ack_mode, input int max_writes, input int exp_cycles);
        int   cyc = 0;
        int   writes = 0;
        int   stall = 0;
        logic a;
        logic busy;
        logic exp_ps_ack;
        while ((vec_q.size() > 0 || exp_q.size() > 0) &&
               !(max_writes >= 0 && writes >= max_writes)) begin
            if (cyc >= 400) begin
                check("timeout", 64'(cyc), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
            ps_rdy = (vec_q.size() > 0);
            if (ps_rdy) begin
                sum           = vec_q[0].s;
                ctl.psum_mode = vec_q[0].mode;
                ctl.addr      = vec_q[0].base;
            end else begin
                for (int i = 0; i < PEROW; i++) sum[i] = $urandom;
                ctl.psum_mode = ($urandom_range(0, 1) == 1) ? PSUM_D16 : PSUM_D32;
                ctl.addr      = AW'($urandom);
            end
            case (ack_mode)
                0: a = 1'b1;
                1: a = ($urandom_range(0, 1) == 1);
                default: begin
                    a = !(exp_q.size() > 0 && exp_q[0].idx == 8'd1 && stall < 3);
                    if (!a) stall++;
                end
            endcase
            bw_ack = a;
            #1;
            busy       = (exp_q.size() > 0);
            exp_ps_ack = !busy || (a && exp_q.size() == 1);
            check("bw_rdy", 64'(bw_rdy), 64'(busy));
            check("ps_ack", 64'(ps_ack), 64'(exp_ps_ack));
            if (busy) begin
                check("bw_addr", 64'(bw_addr), 64'(exp_q[0].addr));
                check("bw_data", 64'(bw_data), 64'(exp_q[0].data));
            end
            if (busy && a) begin
                check("done", 64'(done), 64'(exp_q[0].last));
                void'(exp_q.pop_front());
                writes++;
            end else begin
                check("done_quiet", 64'(done), 64'd0);
            end
            if (ps_rdy && exp_ps_ack) begin
                model_words(vec_q.pop_front());
                stall = 0;
            end
            cyc++;
        end
        if (exp_cycles >= 0) check("cycles", 64'(cyc), 64'(exp_cycles));
    endtask

    initial begin
        rst_n  = 1'b0;
        ps_rdy = 1'b0;
        bw_ack = 1'b0;
        sum    = '0;
        ctl    = '0;
        #1;
        check("rst_bw_rdy", 64'(bw_rdy), 64'd0);
        check("rst_ps_ack", 64'(ps_ack), 64'd1);
        check("rst_addr", 64'(bw_addr), 64'd0);
        check("rst_data", 64'(bw_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // D32 single vector at base 8
        push_vec({32'd4, 32'd3, 32'd2, 32'd1}, PSUM_D32, 8);
        run(0, -1, 5);

        // D16 packing at base 0
        push_vec({32'h4444, 32'h3333, 32'h2222, 32'h1111}, PSUM_D16, 0);
        run(0, -1, 3);

        // Back-pressure on word 1 for 3 cycles
        push_vec({32'hdead0004, 32'hbeef0003, 32'hcafe0002, 32'hf00d0001}, PSUM_D32, 40);
        run(2, -1, 8);

        // Back-to-back D32 vectors with PS_rdy held
        push_vec({32'd14, 32'd13, 32'd12, 32'd11}, PSUM_D32, 100);
        push_vec({32'd24, 32'd23, 32'd22, 32'd21}, PSUM_D32, 200);
        run(0, -1, 9);

        // Address wrap at the top of the buffer
        push_vec({32'ha4, 32'ha3, 32'ha2, 32'ha1}, PSUM_D32, 1022);
        run(0, -1, 5);

        // Reset after two writes discards the rest of the vector
        push_vec({32'hb4, 32'hb3, 32'hb2, 32'hb1}, PSUM_D32, 300);
        run(0, 2, -1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_bw_rdy", 64'(bw_rdy), 64'd0);
        check("midrst_ps_ack", 64'(ps_ack), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        exp_q.delete();
        ps_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("postrst_bw_rdy", 64'(bw_rdy), 64'd0);
        push_vec({32'hc4, 32'hc3, 32'hc2, 32'hc1}, PSUM_D32, 5);
        run(0, -1, 5);

        // Randomized vectors, modes, bases and back-pressure
        for (int t = 0; t < 30; t++) begin
            int nv;
            nv = $urandom_range(1, 3);
            for (int j = 0; j < nv; j++) begin
                logic [PEROW*32-1:0] s;
                for (int i = 0; i < PEROW; i++) s[i*32 +: 32] = $urandom;
                push_vec(s, ($urandom_range(0, 1) == 1) ? PSUM_D16 : PSUM_D32,
                         int'($urandom_range(0, (1 << AW) - 1)));
            end
            run(($urandom_range(0, 2) == 0) ? 0 : 1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
